// File: rtl/param_bank_ctrl.sv
// rtl/param_bank_ctrl.sv - per-channel parameter bank with shadow/active double buffering
// Host writes land in shadow; an apply sequence copies masked channels into the active bank.
module param_bank_ctrl #(
  parameter int NUM_CH  = 4,
  parameter int NUM_REG = 4,
  parameter int DATA_W  = 16,
  parameter logic [DATA_W-1:0] RST_VAL = '0,
  parameter int CH_W    = (NUM_CH  > 1) ? $clog2(NUM_CH)  : 1,
  parameter int REG_W   = (NUM_REG > 1) ? $clog2(NUM_REG) : 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             wr_valid,
  output logic                             wr_ready,
  input  logic [CH_W+REG_W-1:0]            wr_addr,
  input  logic [DATA_W-1:0]                wr_data,
  output logic                             wr_err,
  input  logic                             rd_valid,
  input  logic [CH_W+REG_W-1:0]            rd_addr,
  input  logic                             rd_active,
  output logic                             rd_resp_valid,
  output logic [DATA_W-1:0]                rd_data,
  output logic                             rd_err,
  input  logic                             apply_req,
  input  logic [NUM_CH-1:0]                apply_mask,
  output logic                             apply_busy,
  output logic                             apply_done,
  output logic [NUM_CH*NUM_REG*DATA_W-1:0] param_out
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  localparam logic [CH_W:0]   CH_LIM  = (CH_W+1)'(NUM_CH);
  localparam logic [REG_W:0]  REG_LIM = (REG_W+1)'(NUM_REG);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  logic [DATA_W-1:0] shadow [NUM_CH][NUM_REG];
  logic [DATA_W-1:0] active [NUM_CH][NUM_REG];

  state_t            state, state_d;
  logic [CH_W-1:0]   ch_idx, ch_idx_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [NUM_CH-1:0] pend_mask, pend_mask_d;
  logic              pend_flag, pend_flag_d;
  logic [NUM_CH-1:0] start_mask;
  logic              copy_en;

  logic [CH_W-1:0]   wr_ch, rd_ch, rd_ch_s;
  logic [REG_W-1:0]  wr_reg, rd_reg, rd_reg_s;
  logic              wr_oor, rd_oor;

  assign wr_ch    = wr_addr[CH_W+REG_W-1:REG_W];
  assign wr_reg   = wr_addr[REG_W-1:0];
  assign rd_ch    = rd_addr[CH_W+REG_W-1:REG_W];
  assign rd_reg   = rd_addr[REG_W-1:0];
  assign wr_oor   = ({1'b0, wr_ch} >= CH_LIM) || ({1'b0, wr_reg} >= REG_LIM);
  assign rd_oor   = ({1'b0, rd_ch} >= CH_LIM) || ({1'b0, rd_reg} >= REG_LIM);
  // Clamp so an out-of-range read never indexes past the arrays.
  assign rd_ch_s  = rd_oor ? '0 : rd_ch;
  assign rd_reg_s = rd_oor ? '0 : rd_reg;
  assign wr_ready = ~apply_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ch_idx    <= '0;
      mask_q    <= '0;
      pend_mask <= '0;
      pend_flag <= 1'b0;
    end else begin
      state     <= state_d;
      ch_idx    <= ch_idx_d;
      mask_q    <= mask_d;
      pend_mask <= pend_mask_d;
      pend_flag <= pend_flag_d;
    end
  end

  always_comb begin
    state_d     = state;
    ch_idx_d    = ch_idx;
    mask_d      = mask_q;
    pend_mask_d = pend_mask;
    pend_flag_d = pend_flag;
    apply_busy  = 1'b0;
    apply_done  = 1'b0;
    copy_en     = 1'b0;
    start_mask  = pend_mask | (apply_req ? apply_mask : '0);
    case (state)
      S_IDLE: begin
        if (apply_req || pend_flag) begin
          mask_d      = start_mask;
          ch_idx_d    = '0;
          pend_mask_d = '0;
          pend_flag_d = 1'b0;
          state_d     = (start_mask != '0) ? S_SCAN : S_DONE;
        end
      end
      S_SCAN: begin
        apply_busy = 1'b1;
        copy_en    = mask_q[ch_idx];
        if (ch_idx == LAST_CH) state_d = S_DONE;
        else                   ch_idx_d = ch_idx + CH_W'(1);
      end
      S_DONE: begin
        apply_busy = 1'b1;
        apply_done = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Requests arriving mid-sequence are merged and replayed after one idle cycle.
    if (apply_busy && apply_req) begin
      pend_mask_d = pend_mask | apply_mask;
      pend_flag_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        for (int r = 0; r < NUM_REG; r++) begin
          shadow[c][r] <= RST_VAL;
          active[c][r] <= RST_VAL;
        end
      end
    end else begin
      if (wr_valid && wr_ready && !wr_oor) shadow[wr_ch][wr_reg] <= wr_data;
      if (copy_en) begin
        for (int r = 0; r < NUM_REG; r++) active[ch_idx][r] <= shadow[ch_idx][r];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_err        <= 1'b0;
      rd_resp_valid <= 1'b0;
      rd_err        <= 1'b0;
      rd_data       <= '0;
    end else begin
      wr_err        <= wr_valid && wr_ready && wr_oor;
      rd_resp_valid <= rd_valid;
      rd_err        <= rd_valid && rd_oor;
      if (rd_valid && !rd_oor)
        rd_data <= rd_active ? active[rd_ch_s][rd_reg_s] : shadow[rd_ch_s][rd_reg_s];
      else
        rd_data <= '0;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    for (genvar r = 0; r < NUM_REG; r++) begin : g_reg
      assign param_out[(c*NUM_REG+r)*DATA_W +: DATA_W] = active[c][r];
    end
  end

endmodule

// File: tb/tb_param_bank_ctrl.sv
// tb/tb_param_bank_ctrl.sv - self-checking bench for param_bank_ctrl
// Table vectors, directed multi-cycle sequences and random stimulus against a cycle-schedule model.
module tb_param_bank_ctrl;
  localparam int NCH  = 4;
  localparam int NREG = 4;
  localparam int DW   = 16;
  localparam int PW   = NCH*NREG*DW;
  localparam int PW3  = 3*3*DW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          wr_valid, wr_ready, wr_err, rd_valid, rd_active, rd_resp_valid, rd_err;
  logic [3:0]    wr_addr, rd_addr;
  logic [DW-1:0] wr_data, rd_data;
  logic          apply_req, apply_busy, apply_done;
  logic [NCH-1:0] apply_mask;
  logic [PW-1:0] param_out;

  logic          w3_valid, w3_ready, w3_err, r3_valid, r3_active, r3_resp_valid, r3_err;
  logic [3:0]    w3_addr, r3_addr;
  logic [DW-1:0] w3_data, r3_data;
  logic          a3_req, a3_busy, a3_done;
  logic [2:0]    a3_mask;
  logic [PW3-1:0] p3_out;

  param_bank_ctrl #(.NUM_CH(NCH), .NUM_REG(NREG), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_err(wr_err), .rd_valid(rd_valid), .rd_addr(rd_addr),
    .rd_active(rd_active), .rd_resp_valid(rd_resp_valid), .rd_data(rd_data), .rd_err(rd_err),
    .apply_req(apply_req), .apply_mask(apply_mask), .apply_busy(apply_busy),
    .apply_done(apply_done), .param_out(param_out));

  param_bank_ctrl #(.NUM_CH(3), .NUM_REG(3), .DATA_W(DW)) dut3 (
    .clk(clk), .rst_n(rst_n), .wr_valid(w3_valid), .wr_ready(w3_ready), .wr_addr(w3_addr),
    .wr_data(w3_data), .wr_err(w3_err), .rd_valid(r3_valid), .rd_addr(r3_addr),
    .rd_active(r3_active), .rd_resp_valid(r3_resp_valid), .rd_data(r3_data), .rd_err(r3_err),
    .apply_req(a3_req), .apply_mask(a3_mask), .apply_busy(a3_busy),
    .apply_done(a3_done), .param_out(p3_out));

  // Reference model: register contents plus an apply schedule expressed in cycle numbers.
  logic [DW-1:0] sh_m  [NCH][NREG];
  logic [DW-1:0] act_m [NCH][NREG];
  int            cyc, scan_start, done_cyc;
  logic [NCH-1:0] scan_mask, pend_m;
  bit            pend_f;
  logic          exp_wr_err, exp_rv, exp_rerr;
  logic [DW-1:0] exp_rd;
  int            n_vec, n_err;

  typedef struct {
    logic wv; logic [3:0] wa; logic [DW-1:0] wd;
    logic rv; logic [3:0] ra; logic ract;
    logic exp_rv; logic [DW-1:0] exp_rd;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit busy_at(int c);
    return (c >= scan_start) && (c <= done_cyc);
  endfunction

  function automatic logic [PW-1:0] pack_act();
    logic [PW-1:0] v;
    for (int c = 0; c < NCH; c++)
      for (int r = 0; r < NREG; r++) v[(c*NREG+r)*DW +: DW] = act_m[c][r];
    return v;
  endfunction

  function automatic logic [NREG*DW-1:0] chan(int c);
    return param_out[c*NREG*DW +: NREG*DW];
  endfunction

  function automatic logic [DW-1:0] t3val(int c, int r);
    return DW'((c + 1) * 16'h1111 + r);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++)
      for (int r = 0; r < NREG; r++) begin sh_m[c][r] = '0; act_m[c][r] = '0; end
    cyc = 0; scan_start = -100; done_cyc = -100; scan_mask = '0; pend_m = '0; pend_f = 0;
    exp_wr_err = 0; exp_rv = 0; exp_rerr = 0; exp_rd = '0;
  endtask

  task automatic idle_in();
    wr_valid = 0; wr_addr = '0; wr_data = '0; rd_valid = 0; rd_addr = '0; rd_active = 0;
    apply_req = 0; apply_mask = '0;
  endtask

  task automatic idle3();
    w3_valid = 0; w3_addr = '0; w3_data = '0; r3_valid = 0; r3_addr = '0; r3_active = 0;
    a3_req = 0; a3_mask = '0;
  endtask

  task automatic check_all();
    bit b;
    b = busy_at(cyc);
    chk("wr_ready", wr_ready, !b);
    chk("apply_busy", apply_busy, b);
    chk("apply_done", apply_done, cyc == done_cyc);
    chk("wr_err", wr_err, exp_wr_err);
    chk("rd_resp_valid", rd_resp_valid, exp_rv);
    chk("rd_err", rd_err, exp_rerr);
    if (exp_rv) chk("rd_data", rd_data, exp_rd);
    chk("param_out", param_out, pack_act());
  endtask

  // Inputs for cycle cyc are already driven; advance the model across the edge, then compare.
  task automatic step();
    bit b;
    int k;
    logic [NCH-1:0] m;
    b = busy_at(cyc);
    exp_rv   = rd_valid;
    exp_rerr = 1'b0;
    exp_rd   = !rd_valid ? '0 : rd_active ? act_m[rd_addr[3:2]][rd_addr[1:0]]
                                          : sh_m[rd_addr[3:2]][rd_addr[1:0]];
    k = cyc - scan_start;
    if (b && scan_mask != '0 && k < NCH && scan_mask[k])
      for (int r = 0; r < NREG; r++) act_m[k][r] = sh_m[k][r];
    exp_wr_err = 1'b0;
    if (wr_valid && !b) sh_m[wr_addr[3:2]][wr_addr[1:0]] = wr_data;
    if (b) begin
      if (apply_req) begin pend_m = pend_m | apply_mask; pend_f = 1; end
    end else if (apply_req || pend_f) begin
      m = pend_m | (apply_req ? apply_mask : '0);
      pend_m = '0; pend_f = 0; scan_mask = m;
      scan_start = cyc + 1;
      done_cyc = (m != '0) ? cyc + 1 + NCH : cyc + 1;
    end
    @(posedge clk); #1;
    cyc++;
    check_all();
  endtask

  task automatic write_main(input logic [3:0] a, input logic [DW-1:0] d);
    idle_in(); wr_valid = 1; wr_addr = a; wr_data = d; step(); idle_in();
  endtask

  task automatic step3();
    @(posedge clk); #1;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, nd, d1, d2;
    logic [PW-1:0]  p_save;
    logic [PW3-1:0] e3;
    n_vec = 0; n_err = 0;
    idle_in(); idle3();
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b1;
    model_reset();
    check_all();
    chk("rst_rd_data", rd_data, '0);

    // T2 write/readback, including same-cycle write/read returning the old value.
    tbl[0] = '{1'b1, 4'h9, 16'hBEEF, 1'b0, 4'h0, 1'b0, 1'b0, 16'h0000};
    tbl[1] = '{1'b0, 4'h0, 16'h0000, 1'b1, 4'h9, 1'b0, 1'b1, 16'hBEEF};
    tbl[2] = '{1'b0, 4'h0, 16'h0000, 1'b1, 4'h9, 1'b1, 1'b1, 16'h0000};
    tbl[3] = '{1'b1, 4'h9, 16'h1234, 1'b1, 4'h9, 1'b0, 1'b1, 16'hBEEF};
    tbl[4] = '{1'b0, 4'h0, 16'h0000, 1'b1, 4'h9, 1'b0, 1'b1, 16'h1234};
    tbl[5] = '{1'b1, 4'h0, 16'h00A5, 1'b1, 4'h0, 1'b1, 1'b1, 16'h0000};
    for (int i = 0; i < 6; i++) begin
      idle_in();
      wr_valid = tbl[i].wv; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
      rd_valid = tbl[i].rv; rd_addr = tbl[i].ra; rd_active = tbl[i].ract;
      step();
      chk("tbl_rv", rd_resp_valid, tbl[i].exp_rv);
      if (tbl[i].exp_rv) chk("tbl_rd_data", rd_data, tbl[i].exp_rd);
    end
    idle_in();

    // T3 apply mask 0101 after filling every channel.
    for (int c = 0; c < NCH; c++)
      for (int r = 0; r < NREG; r++) write_main(4'((c << 2) | r), t3val(c, r));
    apply_req = 1; apply_mask = 4'b0101; step(); idle_in();
    chk("t3_wr_ready_t1", wr_ready, 1'b0);
    chk("t3_ch0_before", chan(0), '0);
    step();
    chk("t3_ch0_t2", chan(0), {t3val(0,3), t3val(0,2), t3val(0,1), t3val(0,0)});
    step(); step();
    chk("t3_ch2_t4", chan(2), {t3val(2,3), t3val(2,2), t3val(2,1), t3val(2,0)});
    step();
    chk("t3_done_t5", apply_done, 1'b1);
    chk("t3_wr_ready_t5", wr_ready, 1'b0);
    chk("t3_ch1_kept", chan(1), '0);
    chk("t3_ch3_kept", chan(3), '0);
    step();
    chk("t3_done_gone", apply_done, 1'b0);
    chk("t3_wr_ready_back", wr_ready, 1'b1);

    // T6 zero mask: single DONE cycle, no copy.
    p_save = param_out;
    apply_req = 1; apply_mask = '0; step(); idle_in();
    chk("t6_done", apply_done, 1'b1);
    chk("t6_wr_ready", wr_ready, 1'b0);
    chk("t6_param", param_out, p_save);
    step();
    chk("t6_wr_ready_back", wr_ready, 1'b1);
    chk("t6_done_gone", apply_done, 1'b0);

    // T5 overlapping requests: second mask is held pending and replayed.
    write_main(4'h0, 16'hC0DE);
    write_main(4'hE, 16'hD00D);
    t0 = cyc; nd = 0; d1 = -1; d2 = -1;
    for (int i = 0; i < 30; i++) begin
      idle_in();
      if (i == 0) begin apply_req = 1; apply_mask = 4'b0001; end
      if (i == 2) begin apply_req = 1; apply_mask = 4'b1000; end
      step();
      if (apply_done) begin
        nd++;
        if (nd == 1) begin d1 = cyc; chk("t5_ch3_first", param_out[(3*NREG+2)*DW +: DW], '0); end
        else d2 = cyc;
      end
    end
    chk("t5_done_count", nd, 2);
    chk("t5_done1_cycle", d1, t0 + 1 + NCH);
    chk("t5_done2_cycle", d2, t0 + 2*NCH + 3);
    chk("t5_ch3_final", param_out[(3*NREG+2)*DW +: DW], 16'hD00D);
    chk("t5_ch0_final", param_out[0 +: DW], 16'hC0DE);

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      wr_valid   = $urandom_range(0, 1);
      wr_addr    = 4'($urandom);
      wr_data    = DW'($urandom);
      rd_valid   = $urandom_range(0, 1);
      rd_addr    = 4'($urandom);
      rd_active  = $urandom_range(0, 1);
      apply_req  = ($urandom_range(0, 11) == 0);
      apply_mask = NCH'($urandom);
      step();
    end
    idle_in();
    repeat (20) step();

    // T1 asynchronous reset in the middle of a scan.
    write_main(4'h0, 16'h0F0F);
    write_main(4'h5, 16'hF0F0);
    apply_req = 1; apply_mask = 4'b1111; step(); idle_in();
    step(); step();
    #2; rst_n = 1'b0; #1;
    chk("t1_param_out", param_out, '0);
    chk("t1_apply_busy", apply_busy, 1'b0);
    chk("t1_wr_ready", wr_ready, 1'b1);
    chk("t1_apply_done", apply_done, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    check_all();
    step();

    // T4 out-of-range accesses on a 3x3 instance.
    w3_valid = 1; w3_addr = {2'd3, 2'd0}; w3_data = 16'hFFFF; step3(); idle3();
    chk("t4_wr_err_ch", w3_err, 1'b1);
    w3_valid = 1; w3_addr = {2'd1, 2'd3}; w3_data = 16'hFFFF; step3(); idle3();
    chk("t4_wr_err_reg", w3_err, 1'b1);
    w3_valid = 1; w3_addr = {2'd1, 2'd2}; w3_data = 16'h5A5A; step3(); idle3();
    chk("t4_wr_err_ok", w3_err, 1'b0);
    r3_valid = 1; r3_addr = {2'd3, 2'd1}; step3(); idle3();
    chk("t4_rd_valid", r3_resp_valid, 1'b1);
    chk("t4_rd_err", r3_err, 1'b1);
    chk("t4_rd_data", r3_data, '0);
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < 3; r++) begin
        r3_valid = 1; r3_addr = 4'((c << 2) | r); step3(); idle3();
        chk("t4_rd_ok_err", r3_err, 1'b0);
        chk("t4_shadow", r3_data, (c == 1 && r == 2) ? 16'h5A5A : 16'h0000);
      end
    chk("t4_param_pre", p3_out, '0);
    a3_req = 1; a3_mask = 3'b111; step3(); idle3();
    repeat (6) step3();
    e3 = '0;
    e3[(1*3+2)*DW +: DW] = 16'h5A5A;
    chk("t4_param_post", p3_out, e3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
